wb_arbiter: RTL and testbench

//  Shares the SISC 16-bit register-file write-back path between three producers:
//  ALU (src 0), memory (src 1) and I/O (src 2).
//  - Arbitrates per cycle with valid/ready handshakes.
//  - Drives the 2-bit select of the 3:1 write-back mux (00=ALU, 01=MEM, 10=IO).
//  - Drives the registered write-back data, destination address and write enable.
//  - Sits between the execute/memory stages and the register file.

---
 rtl/sisc_pkg.sv | 17 +
 rtl/wb_arb_pick.sv | 50 +++++
 rtl/wb_arbiter.sv | 103 ++++++++++
 tb/tb_wb_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC write-back definitions: source encodings, default widths and
// the round-robin pointer advance used by wb_arbiter.
package sisc_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;

    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_IO  = 2'b10;

    // Highest priority moves to the source after the winner, wrapping IO back to ALU.
    function automatic logic [1:0] next_ptr(input logic [1:0] src);
        return (src == WB_SRC_IO) ? WB_SRC_ALU : src + 2'd1;
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational 3-way write-back picker. WB_ARB_RR_EN selects round-robin
// starting at ptr; otherwise fixed priority MEM > ALU > IO and ptr is ignored.
module wb_arb_pick
    import sisc_pkg::*;
(
    input  logic [2:0] vld,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic [1:0] src
);

`ifdef WB_ARB_RR_EN
    always_comb begin
        logic [2:0] cand;
        logic       found;
        gnt   = 3'b000;
        src   = WB_SRC_ALU;
        found = 1'b0;
        cand  = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, ptr} + 3'(i);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!found && vld[cand[1:0]]) begin
                found           = 1'b1;
                gnt[cand[1:0]]  = 1'b1;
                src             = cand[1:0];
            end
        end
    end
`else
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    always_comb begin
        gnt = 3'b000;
        src = WB_SRC_ALU;
        if (vld[WB_SRC_MEM]) begin
            gnt[WB_SRC_MEM] = 1'b1;
            src             = WB_SRC_MEM;
        end else if (vld[WB_SRC_ALU]) begin
            gnt[WB_SRC_ALU] = 1'b1;
            src             = WB_SRC_ALU;
        end else if (vld[WB_SRC_IO]) begin
            gnt[WB_SRC_IO]  = 1'b1;
            src             = WB_SRC_IO;
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// SISC register-file write-back arbiter for ALU, MEM and IO producers.
// Define WB_ARB_RR_EN for round-robin; default build is fixed MEM > ALU > IO.
module wb_arbiter
    import sisc_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_vld,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [ADDR_W-1:0] alu_dst,
    output logic              alu_rdy,
    input  logic              mem_vld,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] mem_dst,
    output logic              mem_rdy,
    input  logic              io_vld,
    input  logic [DATA_W-1:0] io_data,
    input  logic [ADDR_W-1:0] io_dst,
    output logic              io_rdy,
    input  logic              wb_stall,
    output logic [1:0]        wb_sel,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_dst,
    output logic              wb_we
);

    logic [2:0]        req;
    logic [2:0]        gnt;
    logic [2:0]        rdy;
    logic [1:0]        src;
    logic [1:0]        rr_ptr;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] sel_dst;

    assign req = {io_vld, mem_vld, alu_vld};

    wb_arb_pick u_pick (
        .vld (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .src (src)
    );

    // Stall and reset only block new grants; the picker itself never sees them.
    assign rdy     = (rst || wb_stall) ? 3'b000 : gnt;
    assign alu_rdy = rdy[WB_SRC_ALU];
    assign mem_rdy = rdy[WB_SRC_MEM];
    assign io_rdy  = rdy[WB_SRC_IO];
    assign xfer    = |rdy;

`ifdef WB_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= WB_SRC_ALU;
        end else if (xfer) begin
            rr_ptr <= next_ptr(src);
        end
    end
`else
    assign rr_ptr = WB_SRC_ALU;
`endif

    always_comb begin
        sel_data = alu_data;
        sel_dst  = alu_dst;
        case (src)
            WB_SRC_MEM: begin
                sel_data = mem_data;
                sel_dst  = mem_dst;
            end
            WB_SRC_IO: begin
                sel_data = io_data;
                sel_dst  = io_dst;
            end
            default: begin
                sel_data = alu_data;
                sel_dst  = alu_dst;
            end
        endcase
    end

    // Grant stage -> registered write-back stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_sel  <= WB_SRC_ALU;
            wb_data <= '0;
            wb_dst  <= '0;
        end else begin
            wb_we <= xfer;
            if (xfer) begin
                wb_sel  <= src;
                wb_data <= sel_data;
                wb_dst  <= sel_dst;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, hand-written corner
// sequences and randomized traffic against a priority-list reference model.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_vld = 1'b0, mem_vld = 1'b0, io_vld = 1'b0;
    logic [15:0] alu_data = '0, mem_data = '0, io_data = '0;
    logic [3:0]  alu_dst = '0, mem_dst = '0, io_dst = '0;
    logic        alu_rdy, mem_rdy, io_rdy;
    logic        wb_stall = 1'b0;
    logic [1:0]  wb_sel;
    logic [15:0] wb_data;
    logic [3:0]  wb_dst;
    logic        wb_we;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .alu_vld(alu_vld), .alu_data(alu_data), .alu_dst(alu_dst), .alu_rdy(alu_rdy),
        .mem_vld(mem_vld), .mem_data(mem_data), .mem_dst(mem_dst), .mem_rdy(mem_rdy),
        .io_vld(io_vld), .io_data(io_data), .io_dst(io_dst), .io_rdy(io_rdy),
        .wb_stall(wb_stall),
        .wb_sel(wb_sel), .wb_data(wb_data), .wb_dst(wb_dst), .wb_we(wb_we)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_ptr  = 0;
    logic        m_we   = 1'b0;
    logic [1:0]  m_sel  = 2'b00;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dst  = '0;
    logic [15:0] rf [16];
    logic [2:0]  act_rdy;
    logic [2:0]  exp_rdy;

    typedef struct {
        logic [2:0]  vld;
        logic        stall;
        logic [15:0] data;
        logic [3:0]  dst;
        logic [2:0]  rdy;
        logic        we;
        logic [1:0]  sel;
        logic [15:0] wdata;
        logic [3:0]  wdst;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the priority list implied by the arbitration rule; -1 means no grant.
    function automatic int model_pick(input logic [2:0] v, input int ptr, input logic stall);
        int order [3];
        if (stall) return -1;
`ifdef WB_ARB_RR_EN
        for (int k = 0; k < 3; k++) order[k] = (ptr + k) % 3;
`else
        order = '{1, 0, 2};
`endif
        for (int k = 0; k < 3; k++)
            if (v[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic set_src(input int s, input logic v, input logic [15:0] d, input logic [3:0] a);
        case (s)
            0: begin alu_vld = v; alu_data = d; alu_dst = a; end
            1: begin mem_vld = v; mem_data = d; mem_dst = a; end
            default: begin io_vld = v; io_data = d; io_dst = a; end
        endcase
    endtask

    // One clock: inputs already driven after the falling edge; ends on the next falling edge.
    task automatic cycle(input bit chk);
        int          g;
        logic [15:0] d;
        logic [3:0]  a;
        #1;
        g       = model_pick({io_vld, mem_vld, alu_vld}, m_ptr, wb_stall);
        exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
        act_rdy = {io_rdy, mem_rdy, alu_rdy};
        d = (g == 1) ? mem_data : (g == 2) ? io_data : alu_data;
        a = (g == 1) ? mem_dst  : (g == 2) ? io_dst  : alu_dst;
        if (chk) check("rdy", 32'(act_rdy), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_we   = 1'b1;
            m_sel  = 2'(g);
            m_data = d;
            m_dst  = a;
            m_ptr  = (g + 1) % 3;
        end else begin
            m_we = 1'b0;
        end
        if (wb_we) rf[wb_dst] = wb_data;
        if (chk) begin
            check("wb_we",   32'(wb_we),   32'(m_we));
            check("wb_sel",  32'(wb_sel),  32'(m_sel));
            check("wb_data", 32'(wb_data), 32'(m_data));
            check("wb_dst",  32'(wb_dst),  32'(m_dst));
        end
        @(negedge clk);
    endtask

    // Called on a falling edge; asserts rst asynchronously mid-cycle.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_we"},   32'(wb_we),   32'd0);
        check({tag, "_sel"},  32'(wb_sel),  32'd0);
        check({tag, "_data"}, 32'(wb_data), 32'd0);
        check({tag, "_dst"},  32'(wb_dst),  32'd0);
        check({tag, "_rdy"},  32'({io_rdy, mem_rdy, alu_rdy}), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_rdy_hold"}, 32'({io_rdy, mem_rdy, alu_rdy}), 32'd0);
        check({tag, "_we_hold"},  32'(wb_we), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        m_we   = 1'b0;
        m_sel  = 2'b00;
        m_data = '0;
        m_dst  = '0;
        m_ptr  = 0;
    endtask

    task automatic clear_all();
        alu_vld = 1'b0; mem_vld = 1'b0; io_vld = 1'b0; wb_stall = 1'b0;
    endtask

    initial begin
        logic [2:0]  pend;
        logic [2:0]  rem;
        logic [1:0]  sel_exp [4];

        for (int i = 0; i < 16; i++) rf[i] = '0;

        tbl[0] = '{3'b010, 1'b0, 16'hBEEF, 4'h3, 3'b010, 1'b1, 2'b01, 16'hBEEF, 4'h3};
        tbl[1] = '{3'b001, 1'b0, 16'h1234, 4'h7, 3'b001, 1'b1, 2'b00, 16'h1234, 4'h7};
        tbl[2] = '{3'b100, 1'b0, 16'h5A5A, 4'hF, 3'b100, 1'b1, 2'b10, 16'h5A5A, 4'hF};
        tbl[3] = '{3'b000, 1'b0, 16'hAAAA, 4'h1, 3'b000, 1'b0, 2'b10, 16'h5A5A, 4'hF};
        tbl[4] = '{3'b001, 1'b1, 16'h7777, 4'h2, 3'b000, 1'b0, 2'b10, 16'h5A5A, 4'hF};
        tbl[5] = '{3'b100, 1'b1, 16'h8888, 4'h4, 3'b000, 1'b0, 2'b10, 16'h5A5A, 4'hF};
        tbl[6] = '{3'b001, 1'b0, 16'h0000, 4'h0, 3'b001, 1'b1, 2'b00, 16'h0000, 4'h0};
        tbl[7] = '{3'b010, 1'b0, 16'hFFFF, 4'hE, 3'b010, 1'b1, 2'b01, 16'hFFFF, 4'hE};

        // Power-on reset
        @(posedge clk);
        #1;
        check("por_we",   32'(wb_we),   32'd0);
        check("por_sel",  32'(wb_sel),  32'd0);
        check("por_data", 32'(wb_data), 32'd0);
        check("por_dst",  32'(wb_dst),  32'd0);
        check("por_rdy",  32'({io_rdy, mem_rdy, alu_rdy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-source vectors, stall and idle holds
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < 3; s++) set_src(s, tbl[i].vld[s], tbl[i].data, tbl[i].dst);
            wb_stall = tbl[i].stall;
            cycle(1'b0);
            check($sformatf("tbl%0d_rdy", i),  32'(act_rdy), 32'(tbl[i].rdy));
            check($sformatf("tbl%0d_we", i),   32'(wb_we),   32'(tbl[i].we));
            check($sformatf("tbl%0d_sel", i),  32'(wb_sel),  32'(tbl[i].sel));
            check($sformatf("tbl%0d_data", i), 32'(wb_data), 32'(tbl[i].wdata));
            check($sformatf("tbl%0d_dst", i),  32'(wb_dst),  32'(tbl[i].wdst));
            clear_all();
        end

        // Stall holds a waiting ALU request, then releases it
        set_src(0, 1'b1, 16'h0C0D, 4'h9);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            check("stall_alu_rdy", 32'(act_rdy), 32'd0);
            check("stall_we", 32'(wb_we), 32'd0);
        end
        wb_stall = 1'b0;
        cycle(1'b1);
        check("unstall_alu_rdy", 32'(act_rdy), 32'b001);
        check("unstall_we", 32'(wb_we), 32'd1);
        check("unstall_data", 32'(wb_data), 32'h0C0D);
        clear_all();

        // Stall raised while a write is registered: the write still issues
        set_src(1, 1'b1, 16'h4321, 4'h6);
        cycle(1'b1);
        clear_all();
        set_src(2, 1'b1, 16'h0F0F, 4'h1);
        wb_stall = 1'b1;
        #1 check("stall_we_issues", 32'(wb_we), 32'd1);
        cycle(1'b1);
        check("stall_io_blocked", 32'(act_rdy), 32'd0);
        clear_all();

        // Reset mid-write with a loser still requesting
        set_src(1, 1'b1, 16'h1111, 4'h2);
        set_src(0, 1'b1, 16'h2222, 4'h4);
        cycle(1'b1);
        rem = 3'b011 & ~act_rdy;
        if (act_rdy[0]) alu_vld = 1'b0;
        if (act_rdy[1]) mem_vld = 1'b0;
        check("midrst_pre_we", 32'(wb_we), 32'd1);
        do_reset("midrst");
        cycle(1'b1);
        check("midrst_rearb", 32'(act_rdy), 32'(rem));
        clear_all();

`ifdef WB_ARB_RR_EN
        // Three-way contention from ptr=0
        do_reset("rr");
        set_src(0, 1'b1, 16'hA000, 4'h1);
        set_src(1, 1'b1, 16'hB000, 4'h2);
        set_src(2, 1'b1, 16'hC000, 4'h3);
        sel_exp = '{2'b00, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1);
            check($sformatf("rr_rdy%0d", i), 32'(act_rdy), 32'(3'(1 << sel_exp[i])));
            check($sformatf("rr_sel%0d", i), 32'(wb_sel), 32'(sel_exp[i]));
        end
        clear_all();
`else
        // Fixed priority: MEM wins while valid, IO only once ALU and MEM drop
        do_reset("fp");
        set_src(0, 1'b1, 16'hA000, 4'h1);
        set_src(1, 1'b1, 16'hB000, 4'h2);
        set_src(2, 1'b1, 16'hC000, 4'h3);
        sel_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            check($sformatf("fp_rdy%0d", i), 32'(act_rdy), 32'b010);
            check($sformatf("fp_sel%0d", i), 32'(wb_sel), 32'(sel_exp[i]));
        end
        mem_vld = 1'b0;
        cycle(1'b1);
        check("fp_alu_rdy", 32'(act_rdy), 32'b001);
        check("fp_alu_sel", 32'(wb_sel), 32'b00);
        alu_vld = 1'b0;
        cycle(1'b1);
        check("fp_io_rdy", 32'(act_rdy), 32'b100);
        check("fp_io_sel", 32'(wb_sel), 32'b10);
        clear_all();
`endif

        // Same destination from ALU and IO; pointer left at 2 by a MEM grant
        do_reset("samedst");
        rf[5] = '0;
        set_src(1, 1'b1, 16'h9999, 4'h8);
        cycle(1'b1);
        clear_all();
        set_src(0, 1'b1, 16'h0001, 4'h5);
        set_src(2, 1'b1, 16'h0002, 4'h5);
        cycle(1'b1);
`ifdef WB_ARB_RR_EN
        check("samedst_first", 32'(act_rdy), 32'b100);
        io_vld = 1'b0;
        cycle(1'b1);
        check("samedst_second", 32'(act_rdy), 32'b001);
        alu_vld = 1'b0;
        cycle(1'b1);
        check("samedst_r5", 32'(rf[5]), 32'h0001);
`else
        check("samedst_first", 32'(act_rdy), 32'b001);
        alu_vld = 1'b0;
        cycle(1'b1);
        check("samedst_second", 32'(act_rdy), 32'b100);
        io_vld = 1'b0;
        cycle(1'b1);
        check("samedst_r5", 32'(rf[5]), 32'h0002);
`endif
        clear_all();

        // Randomized traffic: requesters hold vld/data until accepted
        do_reset("rand");
        pend = 3'b000;
        for (int n = 0; n < 400; n++) begin
            for (int s = 0; s < 3; s++) begin
                if (!pend[s] && $urandom_range(0, 99) < 55) begin
                    pend[s] = 1'b1;
                    set_src(s, 1'b1, 16'($urandom), 4'($urandom));
                end
            end
            wb_stall = ($urandom_range(0, 3) == 0);
            cycle(1'b1);
            for (int s = 0; s < 3; s++) begin
                if (act_rdy[s]) begin
                    pend[s] = 1'b0;
                    set_src(s, 1'b0, 16'h0, 4'h0);
                end
            end
        end
        clear_all();
        cycle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
